pc_sequencer: RTL and testbench

//  Parametrised program-counter unit for the fetch stage; replaces the fixed 16-bit always-enabled PC register.

---
 rtl/pc_sequencer.sv | 171 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential step, stall hold with pending-redirect capture,
// branch/jump redirect, circular return-address stack for call/return, and a terminal HALT state.
module pc_sequencer #(
    parameter int              WIDTH        = 16,
    parameter int              STEP         = 2,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             is_call,
    input  logic             is_ret,
    input  logic             halt_req,
    output logic [WIDTH-1:0] pc_cur,
    output logic [WIDTH-1:0] pc_inc,
    output logic             halted,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    // Modulo-2^WIDTH step; the carry out of the adder is intentionally dropped.
    function automatic logic [WIDTH-1:0] step_pc(input logic [WIDTH-1:0] pc);
        return pc + WIDTH'(STEP);
    endfunction

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    logic             pend_valid_q;
    logic             pend_valid_d;
    logic [WIDTH-1:0] pend_target_q;
    logic [WIDTH-1:0] pend_target_d;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr_q;
    logic [CNT_W-1:0] ras_cnt_q;
    logic [WIDTH-1:0] ras_top;
    logic             ras_full;
    logic             ras_empty;
    logic             push;
    logic             pop;

    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;

    assign pc_inc        = step_pc(pc_q);
    assign pc_cur        = pc_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

    // ras_ptr_q is the next free slot, so the top of stack sits one below it.
    assign ras_top   = ras_mem[ras_ptr_q - PTR_W'(1)];
    assign ras_full  = (ras_cnt_q == RAS_FULL);
    assign ras_empty = (ras_cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // HALT only entered on an unstalled edge, and is left solely through reset.
    always_comb begin
        state_d = state_q;
        if (state_q == RUN && !stall && halt_req) begin
            state_d = HALT;
        end
    end

    always_comb begin
        halted = (state_q == HALT);
    end

    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        push          = 1'b0;
        pop           = 1'b0;
        ovf_d         = 1'b0;
        unf_d         = 1'b0;
        if (state_q == RUN) begin
            if (stall) begin
                // A redirect arriving during a stall is parked; the latest one wins.
                if (redirect_valid) begin
                    pend_valid_d  = 1'b1;
                    pend_target_d = redirect_target;
                end
            end else if (halt_req) begin
                pc_d = pc_q;
            end else if (pend_valid_q) begin
                pc_d         = pend_target_q;
                pend_valid_d = 1'b0;
            end else if (redirect_valid) begin
                pc_d  = redirect_target;
                push  = is_call;
                ovf_d = is_call && ras_full;
            end else if (is_ret) begin
                if (ras_empty) begin
                    pc_d  = pc_inc;
                    unf_d = 1'b1;
                end else begin
                    pc_d = ras_top;
                    pop  = 1'b1;
                end
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_VECTOR;
            pend_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_target_q <= pend_target_d;
    end

    // Full stack wraps onto the oldest entry; count saturates at the depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else if (push) begin
            ras_ptr_q <= ras_ptr_q + PTR_W'(1);
            if (!ras_full) begin
                ras_cnt_q <= ras_cnt_q + CNT_W'(1);
            end
        end else if (pop) begin
            ras_ptr_q <= ras_ptr_q - PTR_W'(1);
            ras_cnt_q <= ras_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[ras_ptr_q] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, wrap, stalled redirect, call/return, RAS limits and HALT.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        is_call;
    logic        is_ret;
    logic        halt_req;
    logic [15:0] pc_cur;
    logic [15:0] pc_inc;
    logic        halted;
    logic        ras_overflow;
    logic        ras_underflow;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(
        .WIDTH(16),
        .STEP(2),
        .RESET_VECTOR(16'h0000),
        .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .is_call(is_call),
        .is_ret(is_ret),
        .halt_req(halt_req),
        .pc_cur(pc_cur),
        .pc_inc(pc_inc),
        .halted(halted),
        .ras_overflow(ras_overflow),
        .ras_underflow(ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 16'h0000;
        is_call         = 1'b0;
        is_ret          = 1'b0;
        halt_req        = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_ctrl();
        repeat (2) tick();
        checks++; if (pc_cur !== 16'h0000) begin errors++; $display("FAIL reset_pc got=%h exp=0000", pc_cur); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (ras_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ras_overflow); end
        checks++; if (ras_underflow !== 1'b0) begin errors++; $display("FAIL reset_unf got=%b exp=0", ras_underflow); end
        rst = 1'b0;
        tick();
        checks++; if (pc_cur !== 16'h0002) begin errors++; $display("FAIL run_pc1 got=%h exp=0002", pc_cur); end
        tick();
        checks++; if (pc_cur !== 16'h0004) begin errors++; $display("FAIL run_pc2 got=%h exp=0004", pc_cur); end
        // park a redirect, then reset asynchronously mid-cycle
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 16'h0AAA;
        tick();
        checks++; if (pc_cur !== 16'h0004) begin errors++; $display("FAIL stall_hold got=%h exp=0004", pc_cur); end
        redirect_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (pc_cur !== 16'h0000) begin errors++; $display("FAIL async_rst_pc got=%h exp=0000", pc_cur); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL async_rst_halted got=%b exp=0", halted); end
        stall = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (pc_cur !== 16'h0002) begin errors++; $display("FAIL rel_pc1 got=%h exp=0002", pc_cur); end
        tick();
        checks++; if (pc_cur !== 16'h0004) begin errors++; $display("FAIL rel_pc2 got=%h exp=0004", pc_cur); end
        tick();
        checks++; if (pc_cur !== 16'h0006) begin errors++; $display("FAIL rel_pc3 got=%h exp=0006", pc_cur); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_target = 16'hFFFE;
        tick();
        checks++; if (pc_cur !== 16'hFFFE) begin errors++; $display("FAIL wrap_setup got=%h exp=fffe", pc_cur); end
        checks++; if (pc_inc !== 16'h0000) begin errors++; $display("FAIL wrap_inc got=%h exp=0000", pc_inc); end
        redirect_valid = 1'b0;
        tick();
        checks++; if (pc_cur !== 16'h0000) begin errors++; $display("FAIL wrap_pc got=%h exp=0000", pc_cur); end
    endtask

    task automatic test_stall_redirect();
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 16'h0100;
        tick();
        checks++; if (pc_cur !== 16'h0000) begin errors++; $display("FAIL stall_c1 got=%h exp=0000", pc_cur); end
        redirect_valid = 1'b0; is_ret = 1'b1;
        tick();
        checks++; if (pc_cur !== 16'h0000) begin errors++; $display("FAIL stall_c2 got=%h exp=0000", pc_cur); end
        is_ret = 1'b0;
        tick();
        checks++; if (pc_cur !== 16'h0000) begin errors++; $display("FAIL stall_c3 got=%h exp=0000", pc_cur); end
        checks++; if (ras_underflow !== 1'b0) begin errors++; $display("FAIL stall_ret_ignored got=%b exp=0", ras_underflow); end
        stall = 1'b0;
        tick();
        checks++; if (pc_cur !== 16'h0100) begin errors++; $display("FAIL pending_apply got=%h exp=0100", pc_cur); end
        tick();
        checks++; if (pc_cur !== 16'h0102) begin errors++; $display("FAIL pending_after got=%h exp=0102", pc_cur); end
        // later redirect overwrites the parked one; pending beats a fresh redirect
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 16'h0200;
        tick();
        redirect_target = 16'h0300;
        tick();
        checks++; if (pc_cur !== 16'h0102) begin errors++; $display("FAIL overwrite_hold got=%h exp=0102", pc_cur); end
        stall = 1'b0; redirect_target = 16'h0400;
        tick();
        checks++; if (pc_cur !== 16'h0300) begin errors++; $display("FAIL overwrite_apply got=%h exp=0300", pc_cur); end
        redirect_valid = 1'b0;
        tick();
        checks++; if (pc_cur !== 16'h0302) begin errors++; $display("FAIL overwrite_after got=%h exp=0302", pc_cur); end
    endtask

    task automatic test_call_ret();
        redirect_valid = 1'b1; redirect_target = 16'h0010;
        tick();
        is_call = 1'b1; redirect_target = 16'h0200;
        tick();
        checks++; if (pc_cur !== 16'h0200) begin errors++; $display("FAIL call_pc got=%h exp=0200", pc_cur); end
        checks++; if (ras_overflow !== 1'b0) begin errors++; $display("FAIL call_ovf got=%b exp=0", ras_overflow); end
        redirect_valid = 1'b0; is_call = 1'b0;
        tick();
        checks++; if (pc_cur !== 16'h0202) begin errors++; $display("FAIL call_step got=%h exp=0202", pc_cur); end
        is_ret = 1'b1;
        tick();
        checks++; if (pc_cur !== 16'h0012) begin errors++; $display("FAIL ret_pc got=%h exp=0012", pc_cur); end
        checks++; if (ras_underflow !== 1'b0) begin errors++; $display("FAIL ret_unf got=%b exp=0", ras_underflow); end
        tick();
        checks++; if (pc_cur !== 16'h0014) begin errors++; $display("FAIL ret_empty_pc got=%h exp=0014", pc_cur); end
        checks++; if (ras_underflow !== 1'b1) begin errors++; $display("FAIL ret_empty_unf got=%b exp=1", ras_underflow); end
        is_ret = 1'b0;
        tick();
        checks++; if (pc_cur !== 16'h0016) begin errors++; $display("FAIL unf_after_pc got=%h exp=0016", pc_cur); end
        checks++; if (ras_underflow !== 1'b0) begin errors++; $display("FAIL unf_pulse_len got=%b exp=0", ras_underflow); end
    endtask

    task automatic test_ras_overflow();
        logic [15:0] exp_ret [4];
        exp_ret[0] = 16'h5002; exp_ret[1] = 16'h4002; exp_ret[2] = 16'h3002; exp_ret[3] = 16'h2002;
        redirect_valid = 1'b1; redirect_target = 16'h1000;
        tick();
        is_call = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            redirect_target = 16'((i + 1) << 12);
            tick();
            checks++; if (pc_cur !== 16'((i + 1) << 12)) begin errors++; $display("FAIL nest_call%0d_pc got=%h exp=%h", i, pc_cur, 16'((i + 1) << 12)); end
            checks++; if (ras_overflow !== (i == 5)) begin errors++; $display("FAIL nest_call%0d_ovf got=%b exp=%b", i, ras_overflow, (i == 5)); end
        end
        redirect_valid = 1'b0; is_call = 1'b0; is_ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (pc_cur !== exp_ret[i]) begin errors++; $display("FAIL lifo_ret%0d got=%h exp=%h", i, pc_cur, exp_ret[i]); end
            checks++; if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin errors++; $display("FAIL lifo_flags%0d got=%b%b exp=00", i, ras_overflow, ras_underflow); end
        end
        tick();
        checks++; if (pc_cur !== 16'h2004) begin errors++; $display("FAIL drained_pc got=%h exp=2004", pc_cur); end
        checks++; if (ras_underflow !== 1'b1) begin errors++; $display("FAIL drained_unf got=%b exp=1", ras_underflow); end
        is_ret = 1'b0;
    endtask

    task automatic test_priority();
        redirect_valid = 1'b1; is_call = 1'b1; redirect_target = 16'h0700;
        tick();
        is_call = 1'b0; is_ret = 1'b1; redirect_target = 16'h0800;
        tick();
        checks++; if (pc_cur !== 16'h0800) begin errors++; $display("FAIL redir_over_ret got=%h exp=0800", pc_cur); end
        redirect_valid = 1'b0;
        tick();
        checks++; if (pc_cur !== 16'h2006) begin errors++; $display("FAIL ret_not_popped got=%h exp=2006", pc_cur); end
        // a call sampled while stalled must not push
        is_ret = 1'b0; stall = 1'b1; redirect_valid = 1'b1; is_call = 1'b1; redirect_target = 16'h0900;
        tick();
        stall = 1'b0; redirect_valid = 1'b0; is_call = 1'b0;
        tick();
        checks++; if (pc_cur !== 16'h0900) begin errors++; $display("FAIL stalled_call_pc got=%h exp=0900", pc_cur); end
        is_ret = 1'b1;
        tick();
        checks++; if (pc_cur !== 16'h0902) begin errors++; $display("FAIL stalled_call_nopush got=%h exp=0902", pc_cur); end
        checks++; if (ras_underflow !== 1'b1) begin errors++; $display("FAIL stalled_call_unf got=%b exp=1", ras_underflow); end
        is_ret = 1'b0;
    endtask

    task automatic test_halt();
        int bad;
        redirect_valid = 1'b1; redirect_target = 16'h0030;
        tick();
        redirect_valid = 1'b0; stall = 1'b1; halt_req = 1'b1;
        tick();
        checks++; if (halted !== 1'b0 || pc_cur !== 16'h0030) begin errors++; $display("FAIL halt_stalled got=%b/%h exp=0/0030", halted, pc_cur); end
        stall = 1'b0;
        tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_enter got=%b exp=1", halted); end
        checks++; if (pc_cur !== 16'h0030) begin errors++; $display("FAIL halt_pc got=%h exp=0030", pc_cur); end
        halt_req = 1'b0; redirect_valid = 1'b1; redirect_target = 16'h0500;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            is_ret  = i[0];
            is_call = i[1];
            tick();
            if (pc_cur !== 16'h0030 || halted !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL halt_frozen got=%0d bad cycles exp=0", bad); end
        clear_ctrl();
        rst = 1'b1;
        #1;
        checks++; if (pc_cur !== 16'h0000 || halted !== 1'b0) begin errors++; $display("FAIL halt_rst got=%b/%h exp=0/0000", halted, pc_cur); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (pc_cur !== 16'h0002 || halted !== 1'b0) begin errors++; $display("FAIL halt_rerun got=%b/%h exp=0/0002", halted, pc_cur); end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_stall_redirect();
        test_call_ret();
        test_ras_overflow();
        test_priority();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
